// File: rtl/alu_rf_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_rf_exec_unit
//
// Register file plus ARM-style data-processing ALU for the course datapath.
// One command is accepted per handshake and walks through IDLE -> EXEC -> WB,
// so a new command can be taken every third cycle. The register at PC_REG
// doubles as the program counter and advances by PC_STEP per accepted command.
//
// Ports:
//   Clk        rising-edge clock for all state
//   RESET      synchronous, active-high reset
//   cmd_valid  command present from the control unit
//   cmd_ready  high while the unit is idle and can take a command
//   cmd_op     ARM data-processing opcode (AND..MVN)
//   cmd_rn     first operand register index
//   cmd_rm     second operand register index
//   cmd_rd     destination register index
//   cmd_s      update NZCV when the command commits
//   pc_load    load the PC register from pc_in on this edge
//   pc_in      external PC value
//   res_valid  one-cycle pulse after a command commits
//   result     ALU result of the last completed command (held)
//   flags      {N,Z,C,V}
//   pc_out     current contents of the PC register
//   dbg_sel    debug register select
//   dbg_data   combinational read of register dbg_sel
// -----------------------------------------------------------------------------
module alu_rf_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter int PC_REG  = NREGS - 1,
   parameter int PC_STEP = 4,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic             Clk,
   input  logic             RESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [AW-1:0]    cmd_rn,
   input  logic [AW-1:0]    cmd_rm,
   input  logic [AW-1:0]    cmd_rd,
   input  logic             cmd_s,
   input  logic             pc_load,
   input  logic [WIDTH-1:0] pc_in,
   output logic             res_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [WIDTH-1:0] pc_out,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;

   localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

   logic [1:0]       state;
   logic [WIDTH-1:0] regs [NREGS];

   logic [3:0]       op_q;
   logic [AW-1:0]    rd_q;
   logic             s_q;
   logic             cin_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] alu_q;
   logic [3:0]       nzcv_q;

   logic             accept;
   logic             is_test;
   logic             wb_write;

   logic [WIDTH-1:0] alu_res;
   logic [3:0]       nzcv_next;
   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic             arith;
   logic [WIDTH:0]   sum;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   // TST/TEQ/CMP/CMN (opcodes 8..11) only ever affect flags
   assign is_test   = (op_q[3:2] == 2'b10);
   assign wb_write  = (state == WB) && !is_test;

   assign pc_out   = regs[PC_IDX];
   assign dbg_data = regs[dbg_sel];

   // Every add/subtract is folded into x + y + cin. Subtraction inverts the
   // subtrahend, so the adder carry-out is directly ARM's NOT-borrow C flag.
   always_comb begin
      add_x   = a_q;
      add_y   = b_q;
      add_cin = 1'b0;
      arith   = 1'b0;
      alu_res = '0;
      case (op_q)
         4'd0, 4'd8:  alu_res = a_q & b_q;
         4'd1, 4'd9:  alu_res = a_q ^ b_q;
         4'd12:       alu_res = a_q | b_q;
         4'd13:       alu_res = b_q;
         4'd14:       alu_res = a_q & ~b_q;
         4'd15:       alu_res = ~b_q;
         4'd2, 4'd10: begin add_y = ~b_q; add_cin = 1'b1;  arith = 1'b1; end
         4'd3:        begin add_x = b_q; add_y = ~a_q; add_cin = 1'b1; arith = 1'b1; end
         4'd4, 4'd11: begin arith = 1'b1; end
         4'd5:        begin add_cin = cin_q; arith = 1'b1; end
         4'd6:        begin add_y = ~b_q; add_cin = cin_q; arith = 1'b1; end
         4'd7:        begin add_x = b_q; add_y = ~a_q; add_cin = cin_q; arith = 1'b1; end
         default:     alu_res = '0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
      if (arith) begin
         alu_res = sum[WIDTH-1:0];
      end
      nzcv_next[3] = alu_res[WIDTH-1];
      nzcv_next[2] = (alu_res == '0);
      // Logical ops leave C and V exactly as they were
      nzcv_next[1] = arith ? sum[WIDTH] : flags[1];
      nzcv_next[0] = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != add_x[WIDTH-1])) : flags[0];
   end

   // Command sequencing: capture operands at accept, register the ALU output
   // in EXEC, and commit result/flags on the edge that leaves WB so res_valid
   // is high during the first IDLE cycle afterwards.
   always_ff @(posedge Clk) begin
      if (RESET) begin
         state     <= IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         s_q       <= 1'b0;
         cin_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         nzcv_q    <= '0;
         res_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= cmd_op;
                  rd_q  <= cmd_rd;
                  s_q   <= cmd_s;
                  cin_q <= flags[1];
                  a_q   <= regs[cmd_rn];
                  b_q   <= regs[cmd_rm];
                  state <= EXEC;
               end
            end
            EXEC: begin
               alu_q  <= alu_res;
               nzcv_q <= nzcv_next;
               state  <= WB;
            end
            WB: begin
               result    <= alu_q;
               res_valid <= 1'b1;
               if (s_q) begin
                  flags <= nzcv_q;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register file. The PC register resolves its writers in priority order:
   // external load, then writeback, then the per-command auto-increment.
   // Accept and writeback never coincide because accept needs the IDLE state.
   always_ff @(posedge Clk) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[AW'(i)] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (AW'(i) == PC_IDX) begin
               if (pc_load) begin
                  regs[AW'(i)] <= pc_in;
               end else if (wb_write && (rd_q == PC_IDX)) begin
                  regs[AW'(i)] <= alu_q;
               end else if (accept) begin
                  regs[AW'(i)] <= regs[AW'(i)] + WIDTH'(PC_STEP);
               end
            end else if (wb_write && (rd_q == AW'(i))) begin
               regs[AW'(i)] <= alu_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rf_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_rf_exec_unit
//
// Self-checking bench for alu_rf_exec_unit (WIDTH=32, NREGS=16). A reference
// model tracks the register file, PC and flags with plain integer arithmetic;
// each command is driven on a falling edge and its commit is checked three
// cycles after accept. Directed scenarios come first, then random commands.
// -----------------------------------------------------------------------------
module tb_alu_rf_exec_unit;

   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   logic        Clk = 1'b0;
   logic        RESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [3:0]  cmd_rn;
   logic [3:0]  cmd_rm;
   logic [3:0]  cmd_rd;
   logic        cmd_s;
   logic        pc_load;
   logic [31:0] pc_in;
   logic        res_valid;
   logic [31:0] result;
   logic [3:0]  flags;
   logic [31:0] pc_out;
   logic [3:0]  dbg_sel;
   logic [31:0] dbg_data;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] mregs [16];
   logic [3:0]  mflags;
   logic [31:0] mresult;

   alu_rf_exec_unit #(
      .WIDTH(32),
      .NREGS(16),
      .PC_REG(15),
      .PC_STEP(4)
   ) dut (
      .Clk(Clk),
      .RESET(RESET),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_rn(cmd_rn),
      .cmd_rm(cmd_rm),
      .cmd_rd(cmd_rd),
      .cmd_s(cmd_s),
      .pc_load(pc_load),
      .pc_in(pc_in),
      .res_valid(res_valid),
      .result(result),
      .flags(flags),
      .pc_out(pc_out),
      .dbg_sel(dbg_sel),
      .dbg_data(dbg_data)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   always #5 Clk = ~Clk;

   // Watchdog so a wedged run still terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference ALU: arithmetic done on wide signed/unsigned integers, with C as
   // "no unsigned overflow/borrow" and V as "signed result out of range".
   function automatic void aluModel(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] fl,
                                    output logic [31:0] r, output logic [3:0] nf);
      longint      sa, sb, t, ci, bo;
      logic [63:0] ua, ub, uci, ubo;
      logic        c, v, arith;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      ua    = {32'd0, a};
      ub    = {32'd0, b};
      ci    = fl[1] ? 64'sd1 : 64'sd0;
      bo    = fl[1] ? 64'sd0 : 64'sd1;
      uci   = fl[1] ? 64'd1 : 64'd0;
      ubo   = fl[1] ? 64'd0 : 64'd1;
      c     = fl[1];
      v     = fl[0];
      arith = 1'b1;
      t     = 0;
      r     = '0;
      case (op)
         4'd4, 4'd11: begin t = sa + sb;      c = (ua + ub) > 64'hFFFFFFFF; end
         4'd5:        begin t = sa + sb + ci; c = (ua + ub + uci) > 64'hFFFFFFFF; end
         4'd2, 4'd10: begin t = sa - sb;      c = (ua >= ub); end
         4'd6:        begin t = sa - sb - bo; c = (ua >= ub + ubo); end
         4'd3:        begin t = sb - sa;      c = (ub >= ua); end
         4'd7:        begin t = sb - sa - bo; c = (ub >= ua + ubo); end
         default: begin
            arith = 1'b0;
            case (op)
               4'd0, 4'd8: r = a & b;
               4'd1, 4'd9: r = a ^ b;
               4'd12:      r = a | b;
               4'd13:      r = b;
               4'd14:      r = a & ~b;
               default:    r = ~b;
            endcase
         end
      endcase
      if (arith) begin
         r = t[31:0];
         v = (t > SMAX) || (t < SMIN);
      end
      nf = {r[31], (r == 32'd0), c, v};
   endfunction

   // Single comparison point: counts the vector and reports any miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkReg(input string tag, input logic [3:0] r,
                           input logic [31:0] expected);
      dbg_sel = r;
      #1;
      checkOutput(tag, dbg_data, expected);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mflags  = '0;
      mresult = '0;
   endtask

   // Issues one command starting on a falling edge and checks its full
   // three-cycle life. plAcc drives pc_load on the accept edge, plWb on the
   // commit edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rn,
                                input logic [3:0] rm, input logic [3:0] rd,
                                input logic s, input logic plAcc,
                                input logic plWb, input logic [31:0] pcv);
      logic [31:0] expR;
      logic [3:0]  expF;
      checkOutput("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_rn    = rn;
      cmd_rm    = rm;
      cmd_rd    = rd;
      cmd_s     = s;
      pc_load   = plAcc;
      pc_in     = pcv;
      dbg_sel   = rd;
      aluModel(op, mregs[rn], mregs[rm], mflags, expR, expF);
      mregs[15] = plAcc ? pcv : mregs[15] + 32'd4;
      @(negedge Clk);
      cmd_valid = 1'b0;
      pc_load   = 1'b0;
      checkOutput("ready_exec", 32'(cmd_ready), 32'd0);
      checkOutput("pc_accept", pc_out, mregs[15]);
      @(negedge Clk);
      checkOutput("valid_early", 32'(res_valid), 32'd0);
      pc_load = plWb;
      pc_in   = pcv;
      @(negedge Clk);
      pc_load = 1'b0;
      if (!(op >= 4'd8 && op <= 4'd11)) mregs[rd] = expR;
      if (s) mflags = expF;
      if (plWb) mregs[15] = pcv;
      mresult = expR;
      checkOutput("res_valid", 32'(res_valid), 32'd1);
      checkOutput("result", result, mresult);
      checkOutput("flags", 32'(flags), 32'(mflags));
      checkOutput("pc_commit", pc_out, mregs[15]);
      checkOutput("rd_value", dbg_data, mregs[rd]);
   endtask

   // Preloads a register by forcing the PC to the value and copying R15
   task automatic loadReg(input logic [3:0] r, input logic [31:0] val);
      pc_load   = 1'b1;
      pc_in     = val;
      mregs[15] = val;
      @(negedge Clk);
      pc_load = 1'b0;
      applyStimulus(4'd13, 4'd0, 4'd15, r, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      RESET     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_rn    = '0;
      cmd_rm    = '0;
      cmd_rd    = '0;
      cmd_s     = 1'b0;
      pc_load   = 1'b0;
      pc_in     = '0;
      dbg_sel   = '0;
      modelReset();

      // Reset held for two cycles, then everything must read zero
      repeat (2) @(negedge Clk);
      RESET = 1'b0;
      checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_pc", pc_out, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      for (int r = 0; r < 16; r++) begin
         @(negedge Clk);
         checkReg("rst_reg", 4'(r), 32'd0);
      end
      @(negedge Clk);

      // ADD R3,R1,R2 with flags
      loadReg(4'd1, 32'd5);
      loadReg(4'd2, 32'd7);
      applyStimulus(4'd4, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("add_r3", dbg_data, 32'd12);
      checkOutput("add_flags", 32'(flags), 32'h0);

      // SUB R4,R1,R2 then CMP R1,R1 targeting R4 (must not write)
      @(negedge Clk);
      applyStimulus(4'd2, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("sub_r4", dbg_data, 32'hFFFFFFFE);
      checkOutput("sub_flags", 32'(flags), 32'h8);
      applyStimulus(4'd10, 4'd1, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("cmp_r4", dbg_data, 32'hFFFFFFFE);
      checkOutput("cmp_flags", 32'(flags), 32'h6);

      // Signed overflow, then a logical op that must keep C/V
      loadReg(4'd5, 32'h7FFFFFFF);
      loadReg(4'd6, 32'd1);
      applyStimulus(4'd4, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("adds_r7", dbg_data, 32'h80000000);
      checkOutput("adds_flags", 32'(flags), 32'h9);
      applyStimulus(4'd0, 4'd6, 4'd6, 4'd8, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("ands_flags", 32'(flags), 32'h1);

      // pc_load beats the auto-increment; writeback to R15 replaces the PC
      applyStimulus(4'd4, 4'd1, 4'd2, 4'd10, 1'b0, 1'b1, 1'b0, 32'h100);
      checkOutput("pcload_pc", pc_out, 32'h100);
      applyStimulus(4'd13, 4'd0, 4'd1, 4'd15, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("mov_pc", pc_out, 32'd5);
      // pc_load on the commit edge beats the R15 writeback
      applyStimulus(4'd13, 4'd0, 4'd2, 4'd15, 1'b0, 1'b0, 1'b1, 32'h200);
      checkOutput("wbload_pc", pc_out, 32'h200);

      // Reset while ADD R9,R1,R2 is in EXEC: no commit, back to idle
      cmd_valid = 1'b1;
      cmd_op    = 4'd4;
      cmd_rn    = 4'd1;
      cmd_rm    = 4'd2;
      cmd_rd    = 4'd9;
      cmd_s     = 1'b1;
      dbg_sel   = 4'd9;
      @(negedge Clk);
      cmd_valid = 1'b0;
      RESET     = 1'b1;
      @(negedge Clk);
      RESET = 1'b0;
      modelReset();
      checkOutput("rstx_valid", 32'(res_valid), 32'd0);
      checkOutput("rstx_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rstx_r9", dbg_data, 32'd0);
      @(negedge Clk);
      checkOutput("rstx_valid2", 32'(res_valid), 32'd0);
      checkOutput("rstx_r9b", dbg_data, 32'd0);
      checkOutput("rstx_pc", pc_out, 32'd0);

      // Random phase: seed registers, then random commands against the model
      for (int i = 0; i < 8; i++) begin
         loadReg(4'($urandom_range(0, 14)), $urandom);
      end
      for (int i = 0; i < 80; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), $urandom);
      end
      for (int r = 0; r < 16; r++) begin
         checkReg("final_reg", 4'(r), mregs[r]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_rf_exec_unit.md
Name: alu_rf_exec_unit

Overview:
Parameterised register-file + ALU execution unit for the course ARM datapath. It accepts one data-processing command per handshake, reads Rn/Rm, executes an ARM-encoded ALU op, and writes Rd back. It updates the NZCV flags and maintains a PC that auto-increments per accepted command. It sits between the control unit (command source) and the memory/PC logic.

Parameters:
WIDTH, 32, datapath and register width in bits (>=8)
NREGS, 16, number of registers, power of two >=4; AW = clog2(NREGS)
PC_REG, NREGS-1, index of the register acting as PC
PC_STEP, 4, PC increment applied per accepted command

Ports:
Clk  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept a command
cmd_op  in  4  ARM data-processing opcode (0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN)
cmd_rn  in  AW  first operand register
cmd_rm  in  AW  second operand register
cmd_rd  in  AW  destination register
cmd_s  in  1  update flags
pc_load  in  1  load PC from pc_in this cycle
pc_in  in  WIDTH  external PC value
res_valid  out  1  one-cycle pulse: result/flags committed
result  out  WIDTH  ALU result of last completed command (held)
flags  out  4  {N,Z,C,V}
pc_out  out  WIDTH  current contents of PC_REG
dbg_sel  in  AW  debug read select
dbg_data  out  WIDTH  combinational read of register dbg_sel

Behaviour:
- Reset (RESET=1 at rising edge): all registers 0, flags 0, result 0, res_valid 0, FSM→IDLE. Any in-flight command is discarded without writeback. Reset has priority over everything.
- FSM states: IDLE, EXEC, WB.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/rn/rm/rd/s, read Rn and Rm into operand registers, and go to EXEC. In the same edge PC_REG += PC_STEP (mod 2^WIDTH). Operands read in this edge see the pre-increment PC value.
- EXEC: cmd_ready=0. Compute the ALU result and the next NZCV into pipeline registers; go to WB.
- WB: cmd_ready=0. Commit: write Rd (except ops 8-11, which never write Rd), update result, update flags if cmd_s, pulse res_valid=1 for exactly this cycle, go to IDLE.
- Throughput: one command per 3 cycles. Latency is accept edge k → res_valid high in cycle after edge k+2.
- Arithmetic is WIDTH bits, wrap-around.
  - C for ADD/ADC/CMN = carry out.
  - C for SUB/SBC/CMP/RSB/RSC = NOT borrow (ARM convention).
  - ADC adds C; SBC computes Rn-Rm-!C; RSC computes Rm-Rn-!C. All use the C value latched at accept.
  - V = signed overflow of the performed add/subtract.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): N and Z updated, C and V preserved.
  - MOV/MVN use Rm only.
  - N = result[WIDTH-1]; Z = (result==0).
- Writeback to PC_REG: the written value replaces PC (no increment that cycle).
- pc_load: PC_REG <= pc_in on that edge.
  - Priority: RESET > pc_load > WB write to PC_REG > auto-increment.
  - If pc_load coincides with a command accept, pc_in wins and the increment is dropped.
- Rn==Rd or Rm==Rd is legal: operands are captured at accept, so there is no hazard. A back-to-back command reads post-WB values, since accept can only occur after WB.
- cmd_* is ignored when cmd_ready=0. The source must hold its command until accepted.
- dbg_data and pc_out are combinational from the register array.

Test Plan:
- Reset then idle: RESET high 2 cycles → all dbg_data=0, flags=0, cmd_ready=1, res_valid=0, pc_out=0.
- Preload R1=5, R2=7 via MOV chain; ADD R3,R1,R2 with s=1 → res_valid 3 cycles after accept; R3=12; flags=0000; pc_out advanced 4 per command.
- SUB R4,R1,R2 (5-7), s=1 → R4=0xFFFFFFFE, flags N=1 Z=0 C=0 V=0. Then CMP R1,R1 → Rd unchanged, flags 0110.
- R5=0x7FFFFFFF, R6=1: ADDS R7,R5,R6 → R7=0x80000000, flags N=1 V=1 C=0. Then ANDS R8,R6,R6 → Z=0, N=0, C/V retained (V=1).
- pc_load=1, pc_in=0x100 in the same cycle as an accept → pc_out=0x100 (not 0x104). Then MOV R15,R1 → pc_out=5 after WB, with no +4 that cycle.
- RESET asserted during EXEC of ADD R9,R1,R2 → no res_valid, R9=0, FSM IDLE, cmd_ready=1 next cycle.
